// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with a registered result and zero flag.
// One operation is accepted at a time over in_valid/in_ready. The result is
// presented with out_valid until the consumer takes it with out_ready.
// Optional build macro: ALU_MULDIV_EN enables the iterative unsigned
// multiply/divide unit (opcodes 11-14). Without it those opcodes complete in
// a single cycle with result 0, and busy is tied low.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int CNTW = SHW + 1;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  state_t           w_acc_state;
  logic             w_accept;
  logic             w_lt_u;
  logic             w_gt_u;
  logic             w_lt_s;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  assign w_accept = in_valid && in_ready;
  assign in_ready = !flush && ((r_state == S_IDLE) ||
                               ((r_state == S_DONE) && out_ready));
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;

  assign w_lt_u  = (num1 < num2);
  assign w_gt_u  = (num1 > num2);
  assign w_lt_s  = ($signed(num1) < $signed(num2));
  assign w_shamt = num2[SHW-1:0];

  // Single-cycle result, computed straight from the inputs on the accept edge
  always_comb begin
    w_single = '0;
    case (opcode)
      4'd0:  w_single = num1 + num2;
      4'd1:  w_single = num1 - num2;
      4'd2:  w_single = num1 & num2;
      4'd3:  w_single = num1 | num2;
      4'd4:  w_single = num1 ^ num2;
      4'd5:  w_single = {{(WIDTH-1){1'b0}}, w_lt_u};
      4'd6:  w_single = {{(WIDTH-1){1'b0}}, w_gt_u};
      4'd7:  w_single = {{(WIDTH-1){1'b0}}, w_lt_s};
      4'd8:  w_single = num1 << w_shamt;
      4'd9:  w_single = num1 >> w_shamt;
      4'd10: w_single = $signed(num1) >>> w_shamt;
      default: w_single = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic               w_is_iter;
  logic [CNTW-1:0]    r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_iter_res;
  logic               w_last;

  assign w_is_iter   = (opcode >= 4'd11) && (opcode <= 4'd14);
  assign w_acc_state = w_is_iter ? S_BUSY : S_DONE;
  assign busy        = (r_state == S_BUSY);
  assign w_last      = (r_cnt == CNTW'(1));

  // One iteration of shift-add multiply or restoring divide.
  // Both share r_acc: multiply keeps {partial product, multiplier}, divide
  // keeps {partial remainder, dividend/quotient}. Divide by zero needs no
  // special case: every trial succeeds, giving all-ones and remainder=num1.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    w_diff  = w_shift[WIDTH-1:0] - r_b;
    w_step  = '0;
    if ((r_op == 4'd11) || (r_op == 4'd12)) begin
      w_step = {w_sum, r_acc[WIDTH-1:1]};
    end else if (w_ge) begin
      w_step = {w_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // Select the half of the final accumulator the opcode asks for
  always_comb begin
    w_iter_res = '0;
    case (r_op)
      4'd11:   w_iter_res = w_step[WIDTH-1:0];
      4'd12:   w_iter_res = w_step[2*WIDTH-1:WIDTH];
      4'd13:   w_iter_res = w_step[WIDTH-1:0];
      4'd14:   w_iter_res = w_step[2*WIDTH-1:WIDTH];
      default: w_iter_res = '0;
    endcase
  end

  // Iterative unit state: operand latch, counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (flush) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept && w_is_iter) begin
      r_op  <= opcode;
      r_b   <= num2;
      r_cnt <= CNTW'(WIDTH);
      r_acc <= {{WIDTH{1'b0}}, num1};
    end else if (r_state == S_BUSY) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  // Result register: loaded on a single-cycle accept or the last iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (flush) begin
      r_result <= r_result;
    end else if (w_accept && !w_is_iter) begin
      r_result <= w_single;
      r_zero   <= (w_single == '0);
    end else if ((r_state == S_BUSY) && w_last) begin
      r_result <= w_iter_res;
      r_zero   <= (w_iter_res == '0);
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_acc_state;
        S_BUSY: if (w_last) w_next = S_DONE;
        S_DONE: if (out_ready) w_next = w_accept ? w_acc_state : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end
`else
  assign w_acc_state = S_DONE;
  assign busy        = 1'b0;

  // Result register: every opcode completes on its accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_single;
      r_zero   <= (w_single == '0);
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_acc_state;
        S_DONE: if (out_ready) w_next = w_accept ? w_acc_state : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=32, hand-computed expectations.
// Expectations for opcodes 11-14 follow the ALU_MULDIV_EN build setting.
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t tv[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .num1     (num1),
    .num2     (num2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] md(input logic [31:0] x);
    return MD ? x : 32'h0;
  endfunction

  // Issue one op with out_ready high and measure how long until out_valid
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output int bcnt, output int rdy_hi);
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    opcode = op; num1 = a; num2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; bcnt = 0; rdy_hi = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) begin
        if (busy) bcnt++;
        if (in_ready) rdy_hi++;
      end
    end while (!out_valid && lat < 200);
    res = result;
    z = zero;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat, bcnt, rdy_hi;
    bit          it;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    opcode = '0; num1 = '0; num2 = '0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst result", result, 32'h0);
    chk("rst zero", {31'b0, zero}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    tv.push_back('{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
    tv.push_back('{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0});
    tv.push_back('{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0});
    tv.push_back('{4'd3,  32'h00FF0000, 32'h000000FF, 32'h00FF00FF, 1'b0});
    tv.push_back('{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0});
    tv.push_back('{4'd7,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0});
    tv.push_back('{4'd5,  32'h80000000, 32'h00000001, 32'h00000000, 1'b1});
    tv.push_back('{4'd6,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0});
    tv.push_back('{4'd10, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0});
    tv.push_back('{4'd8,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0});
    tv.push_back('{4'd9,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0});
    tv.push_back('{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1});
    tv.push_back('{4'd11, 32'h12345678, 32'h00000010, md(32'h23456780), !MD});
    tv.push_back('{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, md(32'hFFFFFFFE), !MD});
    tv.push_back('{4'd11, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1});
    tv.push_back('{4'd12, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1});
    tv.push_back('{4'd13, 32'd100,      32'd7,        md(32'd14), !MD});
    tv.push_back('{4'd14, 32'd100,      32'd7,        md(32'd2),  !MD});
    tv.push_back('{4'd13, 32'h00000005, 32'h00000000, md(32'hFFFFFFFF), !MD});
    tv.push_back('{4'd14, 32'h00001234, 32'h00000000, md(32'h00001234), !MD});

    foreach (tv[i]) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, res, z, lat, bcnt, rdy_hi);
      it = MD && (tv[i].op >= 4'd11) && (tv[i].op <= 4'd14);
      chk($sformatf("v%0d op%0d result", i, tv[i].op), res, tv[i].r);
      chk($sformatf("v%0d op%0d zero", i, tv[i].op), {31'b0, z}, {31'b0, tv[i].z});
      chk($sformatf("v%0d op%0d latency", i, tv[i].op), lat, it ? 32'd33 : 32'd1);
      chk($sformatf("v%0d op%0d busy cycles", i, tv[i].op), bcnt, it ? 32'd32 : 32'd0);
      chk($sformatf("v%0d op%0d in_ready while pending", i, tv[i].op), rdy_hi, 32'd0);
    end

    // Back-to-back single-cycle adds with out_ready held high
    @(negedge clk);
    out_ready = 1'b1; opcode = 4'd0; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      num1 = k; num2 = 10 * k;
      @(negedge clk);
      chk($sformatf("b2b%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d result", k), result, 11 * k);
    end
    in_valid = 1'b0;

    // Hold result with out_ready low, then handshake and accept together
    @(negedge clk);
    out_ready = 1'b0; opcode = 4'd4; num1 = 32'h0F; num2 = 32'hF0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d result", k), result, 32'hFF);
      chk($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; opcode = 4'd0; num1 = 32'd2; num2 = 32'd2; in_valid = 1'b1;
    #1 chk("handshake in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("handshake new result", result, 32'd4);
    chk("handshake out_valid", {31'b0, out_valid}, 32'd1);

    // Flush 10 cycles into a divu with a concurrent request
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; opcode = 4'd13; num1 = 32'd100; num2 = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy mid-div", {31'b0, busy}, {31'b0, MD});
    flush = 1'b1; opcode = 4'd0; num1 = 32'd9; num2 = 32'd9; in_valid = 1'b1;
    #1 chk("flush in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush in_ready after", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("flush no late result", {31'b0, out_valid}, 32'd0);

    // Make result nonzero, then reset in the middle of a mul
    run_op(4'd0, 32'd5, 32'd6, res, z, lat, bcnt, rdy_hi);
    chk("pre-reset result", res, 32'd11);
    @(negedge clk);
    out_ready = 1'b0; opcode = 4'd11; num1 = 32'h12345678; num2 = 32'h10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-mul rst busy", {31'b0, busy}, 32'd0);
    chk("mid-mul rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid-mul rst result", result, 32'h0);
    chk("mid-mul rst zero", {31'b0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd1, 32'd10, 32'd3, res, z, lat, bcnt, rdy_hi);
    chk("post-reset result", res, 32'd7);
    chk("post-reset latency", lat, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
